// File: rtl/sprite_blitter_pkg.sv
// sprite_blitter_pkg: shared types and constants for the sprite draw engine.
//   - sprite-table entry layout {base[24:0], width[9:0], height[9:0]} and
//     the bit positions of each field inside the packed 45-bit word
//   - FSM state encoding
//   - sprite-ID validity check
//   - default screen dimensions
package sprite_blitter_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam int ENTRY_W    = 45;
  localparam int BASE_MSB   = 44;
  localparam int BASE_LSB   = 20;
  localparam int WIDTH_MSB  = 19;
  localparam int WIDTH_LSB  = 10;
  localparam int HEIGHT_MSB = 9;
  localparam int HEIGHT_LSB = 0;

  typedef struct packed {
    logic [24:0] base;
    logic [9:0]  width;
    logic [9:0]  height;
  } sprite_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LATCH,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  // IDs 0..13 are populated except 2, which is reserved.
  function automatic logic id_valid(input logic [5:0] id);
    return (id != 6'd2) && (id <= 6'd13);
  endfunction

endpackage

// File: rtl/sprite_blitter_counter.sv
// blit_counter: walks a sprite row-major.
//   clk, rst      : clock, synchronous active-high reset (clears counters)
//   load, base    : restart the walk at pixel (0,0), address base
//   step          : advance one pixel (col wraps at width-1, row increments)
//   width, height : sprite dimensions, stable for the whole walk
//   row, col, addr: current pixel position and its pixel-memory address
//   last          : current pixel is the final one (row==height-1, col==width-1)
module blit_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [24:0] base,
  input  logic [9:0]  width,
  input  logic [9:0]  height,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic [24:0] addr,
  output logic        last
);

  logic col_end;

  assign col_end = (col == width - 10'd1);
  assign last    = col_end && (row == height - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (load) begin
      row  <= '0;
      col  <= '0;
      addr <= base;
    end else if (step) begin
      addr <= addr + 25'd1;
      if (col_end) begin
        col <= '0;
        row <= row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: draws one sprite per request into the frame buffer.
//   Clk, Reset          : clock, synchronous active-high reset
//   start, sprite_id,
//   pos_x, pos_y        : draw request (sampled only while idle)
//   busy, done, err     : status; done pulses once, err flags an invalid ID
//   tbl_id, tbl_entry   : sprite-table lookup (entry valid one cycle later)
//   mem_rd_*            : pixel-memory read port (data valid with ack)
//   fb_wr_*             : frame-buffer write port
// Pixels off the right/bottom screen edge are skipped without a read;
// pixels equal to TRANSPARENT are read but never written.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int               SCREEN_W    = SCREEN_W_DEF,
  parameter int               SCREEN_H    = SCREEN_H_DEF,
  parameter int               PIX_W       = 16,
  parameter logic [PIX_W-1:0] TRANSPARENT = 16'h0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [5:0]       sprite_id,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [5:0]       tbl_id,
  input  logic [44:0]      tbl_entry,
  output logic             mem_rd_req,
  output logic [24:0]      mem_rd_addr,
  input  logic             mem_rd_ack,
  input  logic [PIX_W-1:0] mem_rd_data,
  output logic             fb_wr_req,
  output logic [9:0]       fb_wr_x,
  output logic [9:0]       fb_wr_y,
  output logic [PIX_W-1:0] fb_wr_data,
  input  logic             fb_wr_ack
);

  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [10:0] SH = 11'(SCREEN_H);

  state_t           state, state_nxt;
  logic [5:0]       id_q;
  logic             err_q;
  logic [9:0]       px_q, py_q;
  logic [9:0]       width_q, height_q;
  logic [PIX_W-1:0] pix_q;

  logic [24:0] entry_base;
  logic [9:0]  entry_width, entry_height;
  logic        entry_bad;

  logic        load, step, last;
  logic [9:0]  row, col;
  logic [24:0] addr;
  logic [10:0] sx, sy;
  logic        clipped;
  logic        opaque_ack;

  assign entry_base   = tbl_entry[BASE_MSB:BASE_LSB];
  assign entry_width  = tbl_entry[WIDTH_MSB:WIDTH_LSB];
  assign entry_height = tbl_entry[HEIGHT_MSB:HEIGHT_LSB];
  assign entry_bad    = !id_valid(id_q) || (entry_width == '0) || (entry_height == '0);

  // 11-bit sums so a sprite hanging past x=1023 / y=1023 still clips.
  assign sx      = {1'b0, px_q} + {1'b0, col};
  assign sy      = {1'b0, py_q} + {1'b0, row};
  assign clipped = (sx >= SW) || (sy >= SH);

  assign opaque_ack = (state == S_READ) && !clipped && mem_rd_ack &&
                      (mem_rd_data != TRANSPARENT);

  assign tbl_id = id_q;

  blit_counter u_cnt (
    .clk    (Clk),
    .rst    (Reset),
    .load   (load),
    .step   (step),
    .base   (entry_base),
    .width  (width_q),
    .height (height_q),
    .row    (row),
    .col    (col),
    .addr   (addr),
    .last   (last)
  );

  // Control state: FSM register, latched ID and error flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      id_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        id_q  <= sprite_id;
        err_q <= 1'b0;
      end
      if (state == S_LATCH) begin
        err_q <= !id_valid(id_q);
      end
    end
  end

  // Datapath registers: only meaningful while the FSM is in the matching
  // state, and every output they feed is gated by state.
  always_ff @(posedge Clk) begin
    if (state == S_IDLE && start) begin
      px_q <= pos_x;
      py_q <= pos_y;
    end
    if (state == S_LATCH) begin
      width_q  <= entry_width;
      height_q <= entry_height;
    end
    if (opaque_ack) begin
      pix_q <= mem_rd_data;
    end
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    step        = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    err         = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    fb_wr_req   = 1'b0;
    fb_wr_x     = '0;
    fb_wr_y     = '0;
    fb_wr_data  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        load      = 1'b1;
        state_nxt = entry_bad ? S_DONE : S_READ;
      end
      S_READ: begin
        if (clipped) begin
          step = 1'b1;
        end else begin
          mem_rd_req  = 1'b1;
          mem_rd_addr = addr;
          if (mem_rd_ack) begin
            if (mem_rd_data == TRANSPARENT) step = 1'b1;
            else                            state_nxt = S_WRITE;
          end
        end
        if (step) state_nxt = last ? S_DONE : S_READ;
      end
      S_WRITE: begin
        fb_wr_req  = 1'b1;
        fb_wr_x    = sx[9:0];
        fb_wr_y    = sy[9:0];
        fb_wr_data = pix_q;
        if (fb_wr_ack) begin
          step      = 1'b1;
          state_nxt = last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed bench for sprite_blitter with a sprite-table
// model, a pixel memory whose data is derived from the address, and
// frame-buffer / memory ack generators with programmable delay.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [5:0]  sprite_id;
  logic [9:0]  pos_x, pos_y;
  logic        busy, done, err;
  logic [5:0]  tbl_id;
  logic [44:0] tbl_entry;
  logic        mem_rd_req, mem_rd_ack;
  logic [24:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        fb_wr_req, fb_wr_ack;
  logic [9:0]  fb_wr_x, fb_wr_y;
  logic [15:0] fb_wr_data;

  always #5 Clk = ~Clk;

  sprite_blitter dut (
    .Clk(Clk), .Reset(Reset), .start(start), .sprite_id(sprite_id),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .err(err),
    .tbl_id(tbl_id), .tbl_entry(tbl_entry),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .fb_wr_req(fb_wr_req), .fb_wr_x(fb_wr_x), .fb_wr_y(fb_wr_y),
    .fb_wr_data(fb_wr_data), .fb_wr_ack(fb_wr_ack)
  );

  // Per-run configuration, set by the stimulus before each draw.
  int cur_base, cur_w, cur_h, cur_px, cur_py;
  bit opaque;
  int rd_dly, wr_dly;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [44:0] tbl_rom(input logic [5:0] id);
    case (id)
      6'd0:    return {25'd307200, 10'd64, 10'd48};
      6'd1:    return {25'd200000, 10'd64, 10'd60};
      6'd3:    return {25'd1000,   10'd0,  10'd5};
      6'd4:    return {25'd5000,   10'd2,  10'd2};
      6'd13:   return {25'd415490, 10'd23, 10'd32};
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] pix(input int a);
    logic [31:0] v;
    v = a;
    return {v[14:0], 1'b1};
  endfunction

  // A read is wrong if it fetches a pixel outside the sprite or one that
  // lands off-screen.
  function automatic bit rd_bad(input int a);
    int off, c, r;
    off = a - cur_base;
    if (off < 0 || off >= cur_w * cur_h) return 1'b1;
    c = off % cur_w;
    r = off / cur_w;
    return (cur_px + c >= 640) || (cur_py + r >= 480);
  endfunction

  // A write must be on-screen, inside the sprite, and carry the pixel
  // fetched from base + row*width + col.
  function automatic bit wr_bad(input int x, input int y, input logic [15:0] d);
    if (x < cur_px || y < cur_py || x - cur_px >= cur_w || y - cur_py >= cur_h) return 1'b1;
    if (x >= 640 || y >= 480) return 1'b1;
    return d != pix(cur_base + (y - cur_py) * cur_w + (x - cur_px));
  endfunction

  always @(posedge Clk) tbl_entry <= tbl_rom(tbl_id);

  int rd_cnt = 0, wr_cnt = 0;
  always @(posedge Clk) begin
    rd_cnt <= (mem_rd_req && !mem_rd_ack) ? rd_cnt + 1 : 0;
    wr_cnt <= (fb_wr_req && !fb_wr_ack) ? wr_cnt + 1 : 0;
  end
  assign mem_rd_ack  = mem_rd_req && (rd_cnt >= rd_dly);
  assign fb_wr_ack   = fb_wr_req && (wr_cnt >= wr_dly);
  assign mem_rd_data = opaque ? pix(int'(mem_rd_addr)) : 16'h0000;

  // Monitor: per-run statistics, restarted whenever a draw is accepted.
  int cyc, rd_n, wr_n, req_n, done_n, done_cyc;
  int order_err, clip_err, map_err, hold_err;
  int first_rd, last_rd, xmin, xmax, ymin, ymax;
  bit done_err, err_seen, seen_r1c0;
  bit prev_rst, prev_rd_req, prev_rd_ack, prev_wr_req, prev_wr_ack;
  logic [24:0] prev_rd_addr;
  logic [9:0]  prev_x, prev_y;
  logic [15:0] prev_d;

  always @(negedge Clk) begin
    if (start && !busy && !Reset) begin
      cyc <= 0; rd_n <= 0; wr_n <= 0; req_n <= 0; done_n <= 0; done_cyc <= -1;
      order_err <= 0; clip_err <= 0; map_err <= 0; hold_err <= 0;
      first_rd <= -1; last_rd <= -1;
      xmin <= 9999; xmax <= -1; ymin <= 9999; ymax <= -1;
      done_err <= 1'b0; err_seen <= 1'b0; seen_r1c0 <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (mem_rd_req || fb_wr_req) req_n <= req_n + 1;
      if (mem_rd_req && mem_rd_ack) begin
        rd_n <= rd_n + 1;
        if (first_rd < 0) first_rd <= int'(mem_rd_addr);
        if (last_rd >= 0 && int'(mem_rd_addr) <= last_rd) order_err <= order_err + 1;
        last_rd <= int'(mem_rd_addr);
        if (rd_bad(int'(mem_rd_addr))) clip_err <= clip_err + 1;
        if (mem_rd_addr == 25'd307264) seen_r1c0 <= 1'b1;
      end
      if (fb_wr_req && fb_wr_ack) begin
        wr_n <= wr_n + 1;
        if (wr_bad(int'(fb_wr_x), int'(fb_wr_y), fb_wr_data)) map_err <= map_err + 1;
        if (int'(fb_wr_x) < xmin) xmin <= int'(fb_wr_x);
        if (int'(fb_wr_x) > xmax) xmax <= int'(fb_wr_x);
        if (int'(fb_wr_y) < ymin) ymin <= int'(fb_wr_y);
        if (int'(fb_wr_y) > ymax) ymax <= int'(fb_wr_y);
      end
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc + 1;
        done_err <= err;
      end
      if (err) err_seen <= 1'b1;
      if (!Reset && !prev_rst) begin
        if ((prev_rd_req && !prev_rd_ack && (!mem_rd_req || mem_rd_addr != prev_rd_addr)) ||
            (prev_rd_req && prev_rd_ack && opaque && mem_rd_req) ||
            (prev_wr_req && !prev_wr_ack && (!fb_wr_req || fb_wr_x != prev_x ||
                                             fb_wr_y != prev_y || fb_wr_data != prev_d)) ||
            (prev_wr_req && prev_wr_ack && fb_wr_req) ||
            (mem_rd_req && fb_wr_req))
          hold_err <= hold_err + 1;
      end
    end
    prev_rst     <= Reset;
    prev_rd_req  <= mem_rd_req;
    prev_rd_ack  <= mem_rd_ack;
    prev_rd_addr <= mem_rd_addr;
    prev_wr_req  <= fb_wr_req;
    prev_wr_ack  <= fb_wr_ack;
    prev_x       <= fb_wr_x;
    prev_y       <= fb_wr_y;
    prev_d       <= fb_wr_data;
  end

  task automatic setup(input int b, input int w, input int h, input int x, input int y);
    cur_base = b; cur_w = w; cur_h = h; cur_px = x; cur_py = y;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after
  // the rising edge that ends cycle 1, having checked tbl_id in cycle 1.
  task automatic start_draw(input logic [5:0] id);
    sprite_id = id;
    pos_x     = 10'(cur_px);
    pos_y     = 10'(cur_py);
    start     = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    @(negedge Clk);
    chk("tbl_id_cycle1", 64'(tbl_id), 64'(id));
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
    end
    @(posedge Clk); #1;
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, err, mem_rd_req, fb_wr_req}), 64'd0);
    chk({tag, "_tbl_addr"}, 64'({tbl_id, mem_rd_addr}), 64'd0);
    chk({tag, "_fb"}, 64'({fb_wr_x, fb_wr_y, fb_wr_data}), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; sprite_id = '0; pos_x = '0; pos_y = '0;
    opaque = 1'b1; rd_dly = 0; wr_dly = 0;
    setup(0, 1, 1, 0, 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_outputs_zero("reset");
    @(posedge Clk); #1;
    Reset = 1'b0;

    // ID 13, fully visible, opaque, immediate acks.
    setup(415490, 23, 32, 0, 0);
    start_draw(6'd13);
    wait_done(20000);
    chk("id13_done_cyc", 64'(done_cyc), 64'd1475);
    chk("id13_reads", 64'(rd_n), 64'd736);
    chk("id13_first_addr", 64'(first_rd), 64'd415490);
    chk("id13_last_addr", 64'(last_rd), 64'd416225);
    chk("id13_order_err", 64'(order_err), 64'd0);
    chk("id13_writes", 64'(wr_n), 64'd736);
    chk("id13_map_err", 64'(map_err), 64'd0);
    chk("id13_x_range", 64'({xmin[15:0], xmax[15:0]}), 64'({16'd0, 16'd22}));
    chk("id13_y_range", 64'({ymin[15:0], ymax[15:0]}), 64'({16'd0, 16'd31}));
    chk("id13_err", 64'(err_seen), 64'd0);
    chk("id13_hold_err", 64'(hold_err), 64'd0);

    // ID 0 hanging off the bottom-right corner.
    setup(307200, 64, 48, 600, 450);
    start_draw(6'd0);
    wait_done(20000);
    chk("id0_writes", 64'(wr_n), 64'd1200);
    chk("id0_reads", 64'(rd_n), 64'd1200);
    chk("id0_clip_read_err", 64'(clip_err), 64'd0);
    chk("id0_map_err", 64'(map_err), 64'd0);
    chk("id0_addr_r1c0_read", 64'(seen_r1c0), 64'd1);
    chk("id0_x_range", 64'({xmin[15:0], xmax[15:0]}), 64'({16'd600, 16'd639}));
    chk("id0_y_range", 64'({ymin[15:0], ymax[15:0]}), 64'({16'd450, 16'd479}));
    chk("id0_done_cyc", 64'(done_cyc), 64'd4275);

    // ID 1, every pixel transparent.
    opaque = 1'b0;
    setup(200000, 64, 60, 0, 0);
    start_draw(6'd1);
    wait_done(20000);
    chk("id1_reads", 64'(rd_n), 64'd3840);
    chk("id1_writes", 64'(wr_n), 64'd0);
    chk("id1_done_n", 64'(done_n), 64'd1);
    chk("id1_done_cyc", 64'(done_cyc), 64'd3843);
    opaque = 1'b1;

    // Delayed acks on both ports: requests hold, then drop after ack.
    rd_dly = 3; wr_dly = 3;
    setup(5000, 2, 2, 10, 10);
    start_draw(6'd4);
    wait_done(2000);
    chk("dly_done_cyc", 64'(done_cyc), 64'd35);
    chk("dly_reads", 64'(rd_n), 64'd4);
    chk("dly_writes", 64'(wr_n), 64'd4);
    chk("dly_hold_err", 64'(hold_err), 64'd0);
    chk("dly_map_err", 64'(map_err), 64'd0);
    rd_dly = 0; wr_dly = 0;

    // Invalid ID 2.
    setup(0, 1, 1, 0, 0);
    start_draw(6'd2);
    wait_done(100);
    chk("id2_done_cyc", 64'(done_cyc), 64'd3);
    chk("id2_err", 64'(done_err), 64'd1);
    chk("id2_reqs", 64'(req_n), 64'd0);

    // Zero-width sprite: done without error.
    setup(1000, 0, 5, 0, 0);
    start_draw(6'd3);
    wait_done(100);
    chk("id3_done_cyc", 64'(done_cyc), 64'd3);
    chk("id3_err", 64'(done_err), 64'd0);
    chk("id3_reqs", 64'(req_n), 64'd0);

    // start while busy must be ignored.
    setup(5000, 2, 2, 10, 10);
    start_draw(6'd4);
    @(posedge Clk); #1;
    sprite_id = 6'd2; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done(200);
    chk("busy_start_done_cyc", 64'(done_cyc), 64'd11);
    chk("busy_start_err", 64'(done_err), 64'd0);
    chk("busy_start_writes", 64'(wr_n), 64'd4);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("busy_start_idle", 64'({busy, 6'(done_n)}), 64'({1'b0, 6'd1}));
    @(posedge Clk); #1;

    // Reset in the middle of a draw, then a normal draw.
    setup(415490, 23, 32, 0, 0);
    start_draw(6'd13);
    repeat (20) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk_outputs_zero("midreset");
    @(posedge Clk); #1;
    setup(5000, 2, 2, 10, 10);
    start_draw(6'd4);
    wait_done(200);
    chk("post_reset_done_cyc", 64'(done_cyc), 64'd11);
    chk("post_reset_writes", 64'(wr_n), 64'd4);
    chk("post_reset_map_err", 64'(map_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
